// File: rtl/gpio_irq.sv
// GPIO peripheral on the 16-bit Wishbone bus: synchronised inputs, atomic output updates,
// per-pin edge detection with sticky pending bits and one level interrupt.
module gpio_irq #(
    parameter int          N        = 16,
    parameter logic [23:0] BASE_ADR = 24'h001010
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [23:0]  wb_adr,
    input  logic         wb_cyc,
    input  logic         wb_stb,
    input  logic         wb_we,
    input  logic [15:0]  wb_i_dat,
    output logic [15:0]  wb_o_dat,
    output logic         wb_ack,
    input  logic [N-1:0] gpio_in,
    output logic [N-1:0] gpio_out,
    output logic [N-1:0] gpio_dir,
    output logic         irq
);

    localparam logic [3:0] REG_IN      = 4'd0;
    localparam logic [3:0] REG_OUT     = 4'd1;
    localparam logic [3:0] REG_DIR     = 4'd2;
    localparam logic [3:0] REG_OUT_SET = 4'd3;
    localparam logic [3:0] REG_OUT_CLR = 4'd4;
    localparam logic [3:0] REG_OUT_TGL = 4'd5;
    localparam logic [3:0] REG_RISE_EN = 4'd6;
    localparam logic [3:0] REG_FALL_EN = 4'd7;
    localparam logic [3:0] REG_PEND    = 4'd8;
    localparam logic [3:0] REG_NONE    = 4'd15;

    logic [N-1:0] sync1_r, sync2_r, prev_r;
    logic [N-1:0] out_r, dir_r, rise_en_r, fall_en_r, pend_r;
    logic         irq_r;

    logic [23:0]  off_s;
    logic         hit_s;
    logic [3:0]   idx_s;
    logic         wr_s;
    logic [N-1:0] wr_dat_s;
    logic [N-1:0] rd_s;
    logic [15:0]  rd_ext_s;
    logic [N-1:0] out_nxt_s, dir_nxt_s, rise_en_nxt_s, fall_en_nxt_s;
    logic [N-1:0] rise_s, fall_s, set_ev_s, clr_s, pend_nxt_s;

    // Address decode: exact match on the nine-word window above BASE_ADR
    always_comb begin
        off_s = wb_adr - BASE_ADR;
        hit_s = (wb_adr >= BASE_ADR) && (off_s < 24'd9);
        if (hit_s) begin
            idx_s = off_s[3:0];
        end else begin
            idx_s = REG_NONE;
        end
        wr_s     = wb_cyc & wb_stb & wb_we;
        wr_dat_s = wb_i_dat[N-1:0];
    end

    // Read mux; write-only and unmapped words read as zero
    always_comb begin
        rd_s = '0;
        case (idx_s)
            REG_IN:      rd_s = sync2_r;
            REG_OUT:     rd_s = out_r;
            REG_DIR:     rd_s = dir_r;
            REG_RISE_EN: rd_s = rise_en_r;
            REG_FALL_EN: rd_s = fall_en_r;
            REG_PEND:    rd_s = pend_r;
            default:     rd_s = '0;
        endcase
        rd_ext_s         = 16'h0000;
        rd_ext_s[N-1:0]  = rd_s;
    end

    assign wb_o_dat = rd_ext_s;
    assign wb_ack   = wb_cyc & wb_stb;

    // Next-state for the bus-writable registers, including atomic OUT updates
    always_comb begin
        out_nxt_s     = out_r;
        dir_nxt_s     = dir_r;
        rise_en_nxt_s = rise_en_r;
        fall_en_nxt_s = fall_en_r;
        clr_s         = '0;
        if (wr_s) begin
            case (idx_s)
                REG_OUT:     out_nxt_s     = wr_dat_s;
                REG_OUT_SET: out_nxt_s     = out_r | wr_dat_s;
                REG_OUT_CLR: out_nxt_s     = out_r & ~wr_dat_s;
                REG_OUT_TGL: out_nxt_s     = out_r ^ wr_dat_s;
                REG_DIR:     dir_nxt_s     = wr_dat_s;
                REG_RISE_EN: rise_en_nxt_s = wr_dat_s;
                REG_FALL_EN: fall_en_nxt_s = wr_dat_s;
                REG_PEND:    clr_s         = wr_dat_s;
                default:     out_nxt_s     = out_r;
            endcase
        end else begin
            out_nxt_s = out_r;
        end
    end

    // Edge detection; a new event on a bit outranks a same-cycle write-1-to-clear
    always_comb begin
        rise_s     = sync2_r & ~prev_r;
        fall_s     = ~sync2_r & prev_r;
        set_ev_s   = dir_r & ((rise_s & rise_en_r) | (fall_s & fall_en_r));
        pend_nxt_s = (pend_r & ~clr_s) | set_ev_s;
    end

    // Synchroniser and edge history
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
            prev_r  <= '0;
        end else begin
            sync1_r <= gpio_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Control/status registers; irq is registered from the next pending value so it tracks PEND exactly
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_r     <= '0;
            dir_r     <= '1;
            rise_en_r <= '0;
            fall_en_r <= '0;
            pend_r    <= '0;
            irq_r     <= 1'b0;
        end else begin
            out_r     <= out_nxt_s;
            dir_r     <= dir_nxt_s;
            rise_en_r <= rise_en_nxt_s;
            fall_en_r <= fall_en_nxt_s;
            pend_r    <= pend_nxt_s;
            irq_r     <= |pend_nxt_s;
        end
    end

    assign gpio_out = out_r;
    assign gpio_dir = dir_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_gpio_irq.sv
// Self-checking bench for gpio_irq: a 16-pin instance at the default base and a 4-pin instance at 24'h002000.
module tb_gpio_irq;

    localparam logic [23:0] B16 = 24'h001010;
    localparam logic [23:0] B4  = 24'h002000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] wadr = 24'h000000;
    logic        cyc16 = 1'b0, cyc4 = 1'b0, stb = 1'b0, wwe = 1'b0;
    logic [15:0] wdat = 16'h0000;
    logic [15:0] dat16, dat4;
    logic        ack16, ack4;
    logic [15:0] gin16 = 16'h0000;
    logic [3:0]  gin4 = 4'h0;
    logic [15:0] gout16, gdir16;
    logic [3:0]  gout4, gdir4;
    logic        irq16, irq4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_item_t;
    sb_item_t sb_q[$];

    typedef struct {
        logic        sel4;
        logic        we;
        logic [23:0] adr;
        logic [15:0] dat;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[19];

    always #5 clk = ~clk;

    gpio_irq dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .wb_adr(wadr), .wb_cyc(cyc16), .wb_stb(stb),
        .wb_we(wwe), .wb_i_dat(wdat), .wb_o_dat(dat16), .wb_ack(ack16),
        .gpio_in(gin16), .gpio_out(gout16), .gpio_dir(gdir16), .irq(irq16)
    );

    gpio_irq #(.N(4), .BASE_ADR(B4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .wb_adr(wadr), .wb_cyc(cyc4), .wb_stb(stb),
        .wb_we(wwe), .wb_i_dat(wdat), .wb_o_dat(dat4), .wb_ack(ack4),
        .gpio_in(gin4), .gpio_out(gout4), .gpio_dir(gdir4), .irq(irq4)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One zero-wait-state bus cycle, started at posedge+1 and finished at the next posedge+1
    task automatic bus(input logic sel4, input logic we, input logic [23:0] adr,
                       input logic [15:0] dat, input logic [15:0] exp, input string name);
        sb_item_t it;
        cyc16 = !sel4;
        cyc4  = sel4;
        stb   = 1'b1;
        wwe   = we;
        wadr  = adr;
        wdat  = dat;
        if (!we) begin
            it.name = name;
            it.exp  = exp;
            sb_q.push_back(it);
        end
        @(negedge clk);
        chk({name, "_ack"}, {15'h0000, (sel4 ? ack4 : ack16)}, 16'h0001);
        if (!we) begin
            it = sb_q.pop_front();
            chk(it.name, sel4 ? dat4 : dat16, it.exp);
        end
        @(posedge clk);
        #1;
        cyc16 = 1'b0;
        cyc4  = 1'b0;
        stb   = 1'b0;
        wwe   = 1'b0;
    endtask

    task automatic run_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            bus(vecs[i].sel4, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].exp, vecs[i].name);
        end
    endtask

    task automatic wr16(input logic [3:0] off, input logic [15:0] d);
        bus(1'b0, 1'b1, B16 + {20'h00000, off}, d, 16'h0000, "wr");
    endtask

    task automatic rd16(input logic [3:0] off, input logic [15:0] e, input string nm);
        bus(1'b0, 1'b0, B16 + {20'h00000, off}, 16'h0000, e, nm);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, B16 + 24'd1, 16'h0000, 16'h0000, "rst_out"};
        vecs[1]  = '{1'b0, 1'b0, B16 + 24'd2, 16'h0000, 16'hFFFF, "rst_dir"};
        vecs[2]  = '{1'b0, 1'b0, B16 + 24'd6, 16'h0000, 16'h0000, "rst_rise_en"};
        vecs[3]  = '{1'b0, 1'b0, B16 + 24'd7, 16'h0000, 16'h0000, "rst_fall_en"};
        vecs[4]  = '{1'b0, 1'b0, B16 + 24'd8, 16'h0000, 16'h0000, "rst_pend"};
        vecs[5]  = '{1'b0, 1'b1, B16 + 24'd1, 16'h00F0, 16'h0000, "w_out"};
        vecs[6]  = '{1'b0, 1'b1, B16 + 24'd3, 16'h0003, 16'h0000, "w_set"};
        vecs[7]  = '{1'b0, 1'b1, B16 + 24'd4, 16'h0010, 16'h0000, "w_clr"};
        vecs[8]  = '{1'b0, 1'b1, B16 + 24'd5, 16'h8001, 16'h0000, "w_tgl"};
        vecs[9]  = '{1'b0, 1'b0, B16 + 24'd1, 16'h0000, 16'h80E2, "atomic_out"};
        vecs[10] = '{1'b0, 1'b0, B16 + 24'd3, 16'h0000, 16'h0000, "rd_set"};
        vecs[11] = '{1'b0, 1'b0, B16 + 24'd4, 16'h0000, 16'h0000, "rd_clr"};
        vecs[12] = '{1'b0, 1'b0, B16 + 24'd5, 16'h0000, 16'h0000, "rd_tgl"};
        vecs[13] = '{1'b1, 1'b1, B4 + 24'd1,  16'hFFFF, 16'h0000, "n4_w_out"};
        vecs[14] = '{1'b1, 1'b0, B4 + 24'd1,  16'h0000, 16'h000F, "n4_out"};
        vecs[15] = '{1'b1, 1'b1, 24'h001011,  16'h0000, 16'h0000, "n4_w_old"};
        vecs[16] = '{1'b1, 1'b0, 24'h001011,  16'h0000, 16'h0000, "n4_rd_old"};
        vecs[17] = '{1'b1, 1'b0, B4 + 24'd1,  16'h0000, 16'h000F, "n4_out_kept"};
        vecs[18] = '{1'b1, 1'b0, B4 + 24'd9,  16'h0000, 16'h0000, "n4_rd_9"};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_gpio_out", gout16, 16'h0000);
        chk("rst_gpio_dir", gdir16, 16'hFFFF);
        chk("rst_irq", {15'h0000, irq16}, 16'h0000);
        chk("idle_ack", {15'h0000, ack16}, 16'h0000);
        run_vecs(0, 12);
        chk("atomic_pins", gout16, 16'h80E2);
        run_vecs(13, 18);
        chk("n4_pins", {12'h000, gout4}, 16'h000F);
        chk("n4_dir", {12'h000, gdir4}, 16'h000F);

        // Synchroniser latency on pin 3
        wr16(4'd6, 16'h0008);
        gin16[3] = 1'b1;
        tick();
        chk("lat_irq_k", {15'h0000, irq16}, 16'h0000);
        rd16(4'd0, 16'h0000, "lat_in_k");
        chk("lat_irq_k1", {15'h0000, irq16}, 16'h0000);
        rd16(4'd0, 16'h0008, "lat_in_k1");
        chk("lat_irq_k2", {15'h0000, irq16}, 16'h0001);
        rd16(4'd8, 16'h0008, "lat_pend_k2");
        wr16(4'd8, 16'h0008);
        chk("lat_irq_clr", {15'h0000, irq16}, 16'h0000);

        // Edge filtering: falls on pin 0 only, then nothing once pin 0 is an output
        wr16(4'd7, 16'h0001);
        gin16[1:0] = 2'b11;
        repeat (4) tick();
        gin16[1:0] = 2'b00;
        repeat (4) tick();
        rd16(4'd8, 16'h0001, "filt_pend");
        wr16(4'd8, 16'h0001);
        rd16(4'd8, 16'h0000, "filt_cleared");
        wr16(4'd2, 16'hFFFE);
        chk("filt_dir_pin", gdir16, 16'hFFFE);
        gin16[1:0] = 2'b11;
        repeat (4) tick();
        gin16[1:0] = 2'b00;
        repeat (4) tick();
        rd16(4'd8, 16'h0000, "filt_out_pin");
        chk("filt_irq", {15'h0000, irq16}, 16'h0000);
        wr16(4'd2, 16'hFFFF);

        // W1C racing a new rise on pin 2
        wr16(4'd6, 16'h0004);
        gin16[2] = 1'b1;
        repeat (4) tick();
        rd16(4'd8, 16'h0004, "race_pend0");
        gin16[2] = 1'b0;
        repeat (4) tick();
        gin16[2] = 1'b1;
        repeat (2) tick();
        wr16(4'd8, 16'h0004);
        chk("race_irq", {15'h0000, irq16}, 16'h0001);
        rd16(4'd8, 16'h0004, "race_pend");
        wr16(4'd8, 16'h0004);
        chk("race_irq_clr", {15'h0000, irq16}, 16'h0000);
        rd16(4'd8, 16'h0000, "race_pend_clr");

        // Asynchronous reset in the middle of an OUT write
        gin16[2] = 1'b0;
        repeat (4) tick();
        gin16[2] = 1'b1;
        repeat (4) tick();
        wr16(4'd2, 16'hFF00);
        chk("pre_rst_irq", {15'h0000, irq16}, 16'h0001);
        cyc16 = 1'b1;
        stb   = 1'b1;
        wwe   = 1'b1;
        wadr  = B16 + 24'd1;
        wdat  = 16'h1234;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", gout16, 16'h0000);
        chk("mid_rst_dir", gdir16, 16'hFFFF);
        chk("mid_rst_irq", {15'h0000, irq16}, 16'h0000);
        cyc16 = 1'b0;
        stb   = 1'b0;
        wwe   = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        run_vecs(0, 4);
        repeat (3) tick();
        rd16(4'd8, 16'h0000, "post_rst_pend");

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
